// File: rtl/dlfloat_dot_seq_if.sv
// Bundle of the sequencer's operand stream, MAC operand lines, result byte
// stream and status lines. The sequencer uses the slave view; the
// surrounding environment (wrappers plus MAC core) uses the master view.
interface dlfloat_dot_seq_if #(
    parameter int LEN_W = 8
);
    // job control
    logic             start;
    logic [LEN_W-1:0] vec_len;
    // operand stream
    logic             op_valid;
    logic [15:0]      op_a;
    logic [15:0]      op_b;
    logic             op_ready;
    // MAC datapath
    logic [15:0]      mac_a;
    logic [15:0]      mac_b;
    logic             mac_clr;
    logic             mac_en;
    logic [15:0]      mac_c;
    // result byte stream
    logic             res_valid;
    logic [7:0]       res_byte;
    logic             res_ready;
    // status
    logic             busy;
    logic             done;
    logic             nan_flag;

    modport slave (
        input  start, vec_len, op_valid, op_a, op_b, mac_c, res_ready,
        output op_ready, mac_a, mac_b, mac_clr, mac_en,
               res_valid, res_byte, busy, done, nan_flag
    );

    modport master (
        output start, vec_len, op_valid, op_a, op_b, mac_c, res_ready,
        input  op_ready, mac_a, mac_b, mac_clr, mac_en,
               res_valid, res_byte, busy, done, nan_flag
    );
endinterface

// File: rtl/dlfloat_dot_seq.sv
// DLFloat16 dot-product job sequencer.
// Clears the MAC accumulator, streams vec_len operand pairs onto the MAC
// operand lines, waits for the MAC pipeline to drain, then returns the
// 16-bit accumulator as two bytes (MSB first).
// Optional sticky NaN/Inf flag: define DLFLOAT_SEQ_NAN_FLAG_EN.
module dlfloat_dot_seq #(
    parameter int LEN_W   = 8,
    parameter int MAC_LAT = 2   // 1..15
) (
    input  logic              clk,
    input  logic              rst_n,
    dlfloat_dot_seq_if.slave  bus
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CLEAR  = 3'd1;
    localparam logic [2:0] S_ACCUM  = 3'd2;
    localparam logic [2:0] S_DRAIN  = 3'd3;
    localparam logic [2:0] S_OUT_HI = 3'd4;
    localparam logic [2:0] S_OUT_LO = 3'd5;

    // Entering DRAIN from ACCUM happens in the cycle the last pair sits on
    // mac_a/mac_b, so one extra cycle is counted before the MAC_LAT window.
    // A zero-length job enters DRAIN straight from CLEAR and waits MAC_LAT.
    localparam logic [3:0] DRAIN_AFTER_PAIRS = 4'(MAC_LAT);
    localparam logic [3:0] DRAIN_ZERO_LEN    = 4'(MAC_LAT - 1);

    logic [2:0]       state_q,    state_d;
    logic [LEN_W-1:0] rem_q,      rem_d;
    logic [3:0]       drain_q,    drain_d;
    logic             zero_len_q, zero_len_d;
    logic [15:0]      result_q,   result_d;
    logic [15:0]      mac_a_q,    mac_a_d;
    logic [15:0]      mac_b_q,    mac_b_d;
    logic             mac_en_q,   mac_en_d;
    logic             done_q,     done_d;

    logic        start_acc;
    logic        pair_acc;
    logic        capture;
    logic [15:0] capture_val;

    // A start arriving in the done cycle is deliberately ignored.
    assign start_acc   = (state_q == S_IDLE) && bus.start && !done_q;
    assign pair_acc    = (state_q == S_ACCUM) && bus.op_valid && (rem_q != '0);
    assign capture     = (state_q == S_DRAIN) && (drain_q == 4'd0);
    assign capture_val = zero_len_q ? 16'h0000 : bus.mac_c;

    // Next-state and datapath register inputs for the job FSM.
    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        drain_d    = drain_q;
        zero_len_d = zero_len_q;
        result_d   = result_q;
        mac_a_d    = 16'h0000;
        mac_b_d    = 16'h0000;
        mac_en_d   = 1'b0;
        done_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_acc) begin
                    rem_d      = bus.vec_len;
                    zero_len_d = (bus.vec_len == '0);
                    state_d    = S_CLEAR;
                end
            end
            S_CLEAR: begin
                if (rem_q != '0) begin
                    state_d = S_ACCUM;
                end else begin
                    drain_d = DRAIN_ZERO_LEN;
                    state_d = S_DRAIN;
                end
            end
            S_ACCUM: begin
                // Idle beats leave zeros on the operand lines, so the
                // accumulator sees a zero product and does not move.
                if (pair_acc) begin
                    mac_a_d  = bus.op_a;
                    mac_b_d  = bus.op_b;
                    mac_en_d = 1'b1;
                    rem_d    = rem_q - 1'b1;
                    if (rem_q == LEN_W'(1)) begin
                        drain_d = DRAIN_AFTER_PAIRS;
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (capture) begin
                    result_d = capture_val;
                    state_d  = S_OUT_HI;
                end else begin
                    drain_d = drain_q - 4'd1;
                end
            end
            S_OUT_HI: begin
                if (bus.res_ready) begin
                    state_d = S_OUT_LO;
                end
            end
            S_OUT_LO: begin
                if (bus.res_ready) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any in-flight job.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            rem_q      <= '0;
            drain_q    <= 4'd0;
            zero_len_q <= 1'b0;
            result_q   <= 16'h0000;
            mac_a_q    <= 16'h0000;
            mac_b_q    <= 16'h0000;
            mac_en_q   <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            drain_q    <= drain_d;
            zero_len_q <= zero_len_d;
            result_q   <= result_d;
            mac_a_q    <= mac_a_d;
            mac_b_q    <= mac_b_d;
            mac_en_q   <= mac_en_d;
            done_q     <= done_d;
        end
    end

    assign bus.op_ready  = (state_q == S_ACCUM);
    assign bus.mac_a     = mac_a_q;
    assign bus.mac_b     = mac_b_q;
    assign bus.mac_clr   = (state_q == S_CLEAR);
    assign bus.mac_en    = mac_en_q;
    assign bus.res_valid = (state_q == S_OUT_HI) || (state_q == S_OUT_LO);
    assign bus.res_byte  = (state_q == S_OUT_HI) ? result_q[15:8] :
                           (state_q == S_OUT_LO) ? result_q[7:0]  : 8'h00;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.done      = done_q;

`ifdef DLFLOAT_SEQ_NAN_FLAG_EN
    logic nan_q, nan_d;

    // Sticky NaN/Inf detector over accepted operands and the captured sum.
    always_comb begin
        nan_d = nan_q;
        if (start_acc) begin
            nan_d = 1'b0;
        end
        if (pair_acc && ((bus.op_a == 16'hFFFF) || (bus.op_b == 16'hFFFF))) begin
            nan_d = 1'b1;
        end
        if (capture && (capture_val == 16'hFFFF)) begin
            nan_d = 1'b1;
        end
    end

    // NaN flag register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nan_q <= 1'b0;
        end else begin
            nan_q <= nan_d;
        end
    end

    assign bus.nan_flag = nan_q;
`else
    assign bus.nan_flag = 1'b0;
`endif

endmodule

// File: tb/tb_dlfloat_dot_seq.sv
// Scoreboard bench for dlfloat_dot_seq with a behavioural MAC model.
module tb_dlfloat_dot_seq;

    localparam int LEN_W   = 8;
    localparam int MAC_LAT = 2;

    logic clk;
    logic rst_n;

    dlfloat_dot_seq_if #(.LEN_W(LEN_W)) bus ();

    dlfloat_dot_seq #(.LEN_W(LEN_W), .MAC_LAT(MAC_LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int en_cnt = 0;
    int clr_cnt = 0;
    int rdy_cnt = 0;
    logic [7:0] exp_q [$];

    // ---------------- behavioural MAC model ----------------
    function automatic real dl2r(input logic [15:0] x);
        real v;
        int  e;
        if (x[14:0] == 15'd0) return 0.0;
        v = 1.0 + real'(x[8:0]) / 512.0;
        e = int'(x[14:9]) - 31;
        while (e > 0) begin v = v * 2.0; e--; end
        while (e < 0) begin v = v / 2.0; e++; end
        return x[15] ? -v : v;
    endfunction

    function automatic logic [15:0] r2dl(input real r);
        real v;
        int  e;
        logic s;
        logic [8:0] m;
        if (r == 0.0) return 16'h0000;
        s = (r < 0.0);
        v = s ? -r : r;
        e = 31;
        while (v >= 2.0 && e < 62) begin v = v / 2.0; e++; end
        while (v < 1.0 && e > 0) begin v = v * 2.0; e--; end
        m = 9'($rtoi((v - 1.0) * 512.0));
        return {s, 6'(e), m};
    endfunction

    real         acc_r;
    logic        acc_nan;
    logic [15:0] acc_enc;
    logic [15:0] dly [0:15];

    assign acc_enc = acc_nan ? 16'hFFFF : r2dl(acc_r);

    always @(posedge clk) begin
        if (!rst_n) begin
            acc_r   <= 0.0;
            acc_nan <= 1'b0;
        end else if (bus.mac_clr) begin
            acc_r   <= 0.0;
            acc_nan <= 1'b0;
        end else if (bus.mac_a == 16'hFFFF || bus.mac_b == 16'hFFFF) begin
            acc_nan <= 1'b1;
        end else begin
            acc_r <= acc_r + dl2r(bus.mac_a) * dl2r(bus.mac_b);
        end
        dly[0] <= acc_enc;
        for (int i = 1; i < 16; i++) dly[i] <= dly[i-1];
    end

    assign bus.mac_c = (MAC_LAT <= 1) ? acc_enc : dly[(MAC_LAT >= 2) ? MAC_LAT - 2 : 0];

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    // Monitor: pops the scoreboard on every accepted result byte.
    always @(negedge clk) begin
        if (bus.mac_en)   en_cnt++;
        if (bus.mac_clr)  clr_cnt++;
        if (bus.op_ready) rdy_cnt++;
        if (bus.res_valid && bus.res_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL res_unexpected: got byte %0h, expected no byte", bus.res_byte);
            end else begin
                check("res_byte", {24'd0, bus.res_byte}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input logic [LEN_W-1:0] len);
        bus.start   = 1'b1;
        bus.vec_len = len;
        tick();
        bus.start   = 1'b0;
    endtask

    task automatic send_pair(input logic [15:0] a, input logic [15:0] b, input bit gap);
        bit got;
        got = 1'b0;
        if (gap) begin
            bus.op_valid = 1'b0;
            tick();
        end
        bus.op_valid = 1'b1;
        bus.op_a     = a;
        bus.op_b     = b;
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge clk);
            got = bus.op_ready;
            tick();
        end
        bus.op_valid = 1'b0;
        if (!got) check("pair_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_res_valid(input string name);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 300 && !seen; k++) begin
            @(negedge clk);
            seen = bus.res_valid;
        end
        check(name, {31'd0, seen}, 32'd1);
    endtask

    task automatic wait_done(input string name);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 300 && !seen; k++) begin
            @(negedge clk);
            seen = bus.done;
        end
        check(name, {31'd0, seen}, 32'd1);
        check({name, "_idle"}, {31'd0, bus.busy}, 32'd0);
    endtask

    task automatic clear_counts();
        en_cnt  = 0;
        clr_cnt = 0;
        rdy_cnt = 0;
    endtask

    // ---------------- directed test sequence ----------------
    initial begin
        int lat;
        bus.start     = 1'b0;
        bus.vec_len   = '0;
        bus.op_valid  = 1'b0;
        bus.op_a      = 16'h0000;
        bus.op_b      = 16'h0000;
        bus.res_ready = 1'b0;
        rst_n         = 1'b0;
        repeat (3) tick();

        // reset state
        @(negedge clk);
        check("rst_ctrl", {26'd0, bus.op_ready, bus.mac_clr, bus.mac_en,
                           bus.res_valid, bus.busy, bus.done}, 32'd0);
        check("rst_mac", {bus.mac_a, bus.mac_b}, 32'd0);
        check("rst_res", {23'd0, bus.nan_flag, bus.res_byte}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // basic job: 1.0*2.0 + 1.0*2.0 = 4.0 (16'h4200)
        clear_counts();
        bus.res_ready = 1'b1;
        exp_q.push_back(8'h42);
        exp_q.push_back(8'h00);
        start_job(8'd2);
        send_pair(16'h3E00, 16'h4000, 1'b0);
        send_pair(16'h3E00, 16'h4000, 1'b0);
        wait_done("basic_done");
        check("basic_mac_en", en_cnt, 32'd2);
        check("basic_mac_clr", clr_cnt, 32'd1);
        tick();

        // zero-length job: latency 2+MAC_LAT, no operand traffic
        clear_counts();
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h00);
        bus.start   = 1'b1;
        bus.vec_len = 8'd0;
        lat = -1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (bus.res_valid) begin
                lat = k;
                break;
            end
            tick();
            bus.start = 1'b0;
        end
        bus.start = 1'b0;
        check("zero_latency", lat, 32'(2 + MAC_LAT));
        wait_done("zero_done");
        check("zero_mac_en", en_cnt, 32'd0);
        check("zero_op_ready", rdy_cnt, 32'd0);
        tick();

        // back-pressure: gapped operands, 5-cycle stall on the MSB byte
        clear_counts();
        bus.res_ready = 1'b0;
        exp_q.push_back(8'h42);
        exp_q.push_back(8'h00);
        start_job(8'd2);
        send_pair(16'h3E00, 16'h4000, 1'b1);
        send_pair(16'h3E00, 16'h4000, 1'b1);
        wait_res_valid("bp_res_valid");
        for (int i = 0; i < 5; i++) begin
            tick();
            @(negedge clk);
            check("bp_stall_hold", {23'd0, bus.res_valid, bus.res_byte}, {23'd0, 1'b1, 8'h42});
        end
        tick();
        bus.res_ready = 1'b1;
        wait_done("bp_done");
        check("bp_mac_en", en_cnt, 32'd2);
        tick();

        // reset in the middle of a 3-pair job
        start_job(8'd3);
        send_pair(16'h3E00, 16'h4000, 1'b0);
        @(negedge clk);
        check("pre_rst_busy", {31'd0, bus.busy}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_ctrl", {26'd0, bus.op_ready, bus.mac_clr, bus.mac_en,
                              bus.res_valid, bus.busy, bus.done}, 32'd0);
        check("midrst_mac", {bus.mac_a, bus.mac_b}, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        exp_q.push_back(8'h3E);
        exp_q.push_back(8'h00);
        start_job(8'd1);
        send_pair(16'h3E00, 16'h3E00, 1'b0);
        wait_done("post_rst_done");
        tick();

        // ignored starts: during ACCUM, during OUT_LO, and in the done cycle
        clear_counts();
        bus.res_ready = 1'b0;
        exp_q.push_back(8'h42);
        exp_q.push_back(8'h00);
        start_job(8'd2);
        send_pair(16'h3E00, 16'h4000, 1'b0);
        bus.start   = 1'b1;
        bus.vec_len = 8'd5;
        @(negedge clk);
        check("ign_accum_state", {30'd0, bus.op_ready, bus.busy}, 32'd3);
        tick();
        bus.start = 1'b0;
        send_pair(16'h3E00, 16'h4000, 1'b0);
        @(negedge clk);
        check("ign_no_relatch", {31'd0, bus.op_ready}, 32'd0);
        wait_res_valid("ign_res_valid");
        tick();
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        bus.start     = 1'b1;
        bus.vec_len   = 8'd7;
        @(negedge clk);
        check("ign_outlo_state", {22'd0, bus.res_valid, bus.busy, bus.res_byte}, {22'd0, 2'b11, 8'h00});
        tick();
        bus.start     = 1'b0;
        bus.res_ready = 1'b1;
        wait_done("ign_done");
        bus.start   = 1'b1;
        bus.vec_len = 8'd3;
        tick();
        bus.start = 1'b0;
        @(negedge clk);
        check("ign_done_cycle_start", {31'd0, bus.busy}, 32'd0);
        check("ign_mac_en", en_cnt, 32'd2);
        tick();

        // NaN operand: passed through, result 16'hFFFF
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'hFF);
        start_job(8'd1);
        send_pair(16'hFFFF, 16'h3E00, 1'b0);
        wait_res_valid("nan_res_valid");
`ifdef DLFLOAT_SEQ_NAN_FLAG_EN
        check("nan_flag_set", {31'd0, bus.nan_flag}, 32'd1);
`else
        check("nan_flag_tied", {31'd0, bus.nan_flag}, 32'd0);
`endif
        wait_done("nan_done");
        tick();
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h00);
        start_job(8'd0);
        @(negedge clk);
        check("nan_flag_cleared", {31'd0, bus.nan_flag}, 32'd0);
        wait_done("nan_clear_done");
        tick();

        check("sb_empty", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
